dnn_train_controller: RTL and testbench
=======================================

// Module: dnn_train_controller
// PURPOSE
//  Mode-driven datapath controller for a small DNN accelerator: holds a weight RAM and an activation RAM.
//  Capabilities: streams words in, runs dot-product (MAC) passes with optional ReLU, streams RAM contents out.
//  Single 32-bit in/out data path; the host sequences operations purely through the mode word.
// PARAMETERS
//  WIDTH   32   data word width (in_data/out_data, RAM entries)
//  DEPTH   256  entries per RAM; addresses are 8 bits, wrap mod DEPTH
//  ACC_W   72   MAC accumulator width (signed)
// PORTS
//  clk       in   1      rising-edge clock
//  enable    in   1      clock enable; 0 = every register and RAM holds
//  reset     in   1      synchronous, active-high reset
//  mode      in   32     operation word (fields below)
//  in_data   in   32     signed data input (LOAD)
//  out_data  out  32     signed registered result / stream output
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high (ports clk, reset); reset beats enable.
//  Reset: out_data=0, prev_mode=0, pointers=0, acc=0, state IDLE.
//    RAM contents are not cleared.
//  mode fields:
//    [3:0]   op: 0 IDLE, 1 MAC, 2 LOAD, 3 DUMP, others = IDLE
//    [4]     ReLU (MAC)
//    [6]     RAM select (LOAD/DUMP): 1 weight, 0 activation
//    [15:8]  N (MAC length) or start addr (LOAD/DUMP)
//    [23:16] weight base (MAC)
//    [31:24] activation base (MAC)
//  Mode start: prev_mode register. On an enabled cycle with mode!=prev_mode, the op restarts:
//    pointer<=start addr/base, count<=0, acc<=0.
//    Same mode held = op continues; a mode change mid-op aborts the old op immediately.
//  IDLE: out_data holds; no RAM writes.
//  LOAD: every enabled cycle, RAM[sel][ptr] <= in_data and ptr <= ptr+1 (wraps 255->0).
//    The first write of a new LOAD lands at the start address; out_data holds.
//  MAC: acc += W[wbase+i]*A[abase+i] for i=0..N-1, addresses wrap mod DEPTH.
//    Signed 32x32 products; RAM reads are synchronous with 1-cycle latency.
//    out_data updates exactly N+2 enabled cycles after the mode-start cycle, then holds until the mode changes.
//    N=0 gives out_data=0 at +2.
//    ReLU: negative result -> 0.
//  DUMP: out_data <= RAM[sel][ptr] each enabled cycle with 1-cycle read latency; ptr increments and wraps.
//    First word (start addr) appears 1 cycle after mode start.
//  Simultaneous LOAD write and DUMP/MAC read of the same RAM cannot occur (one op at a time).
// CONFIGURATION
//  SATURATE_EN defined: MAC result clamped to [0x80000000, 0x7FFFFFFF] before ReLU.
//  SATURATE_EN undefined: MAC result is acc[31:0] (two's-complement truncation).
// TESTING
//  1 Load + MAC: LOAD 0x0042 in 3,-2; LOAD 0x0002 in 5,7; mode 0x000201 -> out_data=1 at cycle +4.
//  2 ReLU: weights -3,1 / acts 5,7; mode 0x000211 -> out_data=0; same with 0x000201 -> -8.
//  3 Dump: after test 1, mode 0x0003 -> out_data 5, 7 on cycles +1, +2; mode 0x0043 -> 3, -2.
//  4 Enable/reset: enable=0 mid-MAC for 5 cycles -> out_data and count frozen, result 5 cycles later.
//    Reset mid-MAC -> out_data=0 next edge.
//  5 Saturation: W=A=0x7FFFFFFF at addr 0,1; mode 0x000201 -> 0x7FFFFFFF with SATURATE_EN.
//    Without SATURATE_EN -> 0x00000002.
//  6 Wrap: LOAD 0xFF42 in 9,4 -> W[255]=9, W[0]=4; MAC 0x00FF0201 -> uses addresses 255 then 0.

Source files
------------

// File: rtl/dnn_train_controller.sv
// dnn_train_controller: mode-word driven LOAD / MAC / DUMP controller over weight and activation RAMs.
// Build option: `define SATURATE_EN clamps the MAC result to signed 32 bits instead of truncating.
module dnn_train_controller #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int ACC_W = 72
) (
  input  logic             clk,
  input  logic             enable,
  input  logic             reset,
  input  logic [31:0]      mode,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data
);
  typedef enum logic [1:0] {IDLE, MAC, LOAD, DUMP} state_t;
  logic [WIDTH-1:0] w_ram [DEPTH];
  logic [WIDTH-1:0] a_ram [DEPTH];
  logic [WIDTH-1:0] w_rd_q, a_rd_q;
  logic [31:0] prev_mode_q, prev_mode_d;
  state_t state_q, state_d, op_dec, op;
  logic [7:0] wptr_q, wptr_d, aptr_q, aptr_d, ld_ptr;
  logic [8:0] count_q, count_d, n;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] out_q, out_d, sat, res;
  logic start, we_w, we_a;
  always_comb begin
    start = mode != prev_mode_q;
    op_dec = (mode[3:2] == 2'b00) ? state_t'(mode[1:0]) : IDLE;
    op = start ? op_dec : state_q;
    n = {1'b0, mode[15:8]};
    ld_ptr = start ? mode[15:8] : wptr_q;
    prod = $signed(w_rd_q) * $signed(a_rd_q);
`ifdef SATURATE_EN
    sat = (!acc_q[ACC_W-1] && |acc_q[ACC_W-2:WIDTH-1]) ? {1'b0, {(WIDTH-1){1'b1}}} :
          (acc_q[ACC_W-1] && !(&acc_q[ACC_W-2:WIDTH-1])) ? {1'b1, {(WIDTH-1){1'b0}}} :
          acc_q[WIDTH-1:0];
`else
    sat = acc_q[WIDTH-1:0];
`endif
    res = (mode[4] && sat[WIDTH-1]) ? '0 : sat;
    prev_mode_d = mode;
    state_d = op_dec;
    wptr_d = start ? ((op_dec == MAC) ? mode[23:16] : mode[15:8]) : wptr_q;
    aptr_d = start ? mode[31:24] : aptr_q;
    count_d = start ? '0 : count_q;
    acc_d = start ? '0 : acc_q;
    out_d = out_q;
    we_w = 1'b0;
    we_a = 1'b0;
    if (op == LOAD) begin
      we_w = mode[6] && !reset;
      we_a = !mode[6] && !reset;
      wptr_d = ld_ptr + 8'd1;
    end
    if (op == DUMP && !start) begin
      out_d = mode[6] ? w_ram[wptr_q] : a_ram[wptr_q];
      wptr_d = wptr_q + 8'd1;
    end
    // count = enabled cycles since start; reads lead the accumulate by one cycle
    if (op == MAC && !start) begin
      if (count_q < n) begin
        wptr_d = wptr_q + 8'd1;
        aptr_d = aptr_q + 8'd1;
      end
      if (count_q != 9'd0 && count_q <= n) acc_d = acc_q + ACC_W'(prod);
      if (count_q == n + 9'd1) out_d = res;
      if (count_q <= n + 9'd1) count_d = count_q + 9'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_mode_q <= '0;
      state_q <= IDLE;
      wptr_q <= '0;
      aptr_q <= '0;
      count_q <= '0;
      acc_q <= '0;
      out_q <= '0;
    end else if (enable) begin
      prev_mode_q <= prev_mode_d;
      state_q <= state_d;
      wptr_q <= wptr_d;
      aptr_q <= aptr_d;
      count_q <= count_d;
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end
  always_ff @(posedge clk) begin
    if (enable) begin
      if (we_w) w_ram[ld_ptr] <= in_data;
      if (we_a) a_ram[ld_ptr] <= in_data;
      w_rd_q <= w_ram[wptr_q];
      a_rd_q <= a_ram[aptr_q];
    end
  end
  assign out_data = out_q;
endmodule

// File: tb/tb_dnn_train_controller.sv
// tb_dnn_train_controller: randomized and directed LOAD/MAC/DUMP sequences checked by a negedge monitor
module tb_dnn_train_controller;
  logic clk = 1'b0;
  logic enable, reset;
  logic [31:0] mode, in_data, out_data;
  dnn_train_controller dut (.clk(clk), .enable(enable), .reset(reset), .mode(mode), .in_data(in_data), .out_data(out_data));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int c; logic [31:0] v; string t;} exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int passed = 0, total = 0;
  logic [31:0] wm [256];
  logic [31:0] am [256];
  logic [31:0] mout = '0;
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].c <= cyc) begin
      mon_e = sbq.pop_front();
      total++;
      if (mon_e.c == cyc && out_data === mon_e.v) passed++;
      else $display("FAIL %s cyc %0d: out_data=%h expected %h (due cyc %0d)", mon_e.t, cyc, out_data, mon_e.v, mon_e.c);
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic void push(int c, logic [31:0] v, string t);
    exp_t e;
    e.c = c;
    e.v = v;
    e.t = t;
    sbq.push_back(e);
  endfunction
  function automatic logic [31:0] mac_ref(int n, logic [7:0] wb, logic [7:0] ab, bit relu);
    logic signed [71:0] s, p;
    logic [31:0] r;
    logic [7:0] wi, ai;
    s = '0;
    for (int i = 0; i < n; i++) begin
      wi = wb + 8'(i);
      ai = ab + 8'(i);
      p = 72'($signed(wm[wi])) * 72'($signed(am[ai]));
      s = s + p;
    end
`ifdef SATURATE_EN
    if (s > 72'sd2147483647) r = 32'h7FFFFFFF;
    else if (s < -72'sd2147483648) r = 32'h80000000;
    else r = s[31:0];
`else
    r = s[31:0];
`endif
    if (relu && $signed(r) < 0) r = '0;
    return r;
  endfunction
  task automatic idle();
    mode = '0;
    enable = 1'b1;
    push(cyc + 1, mout, "idle_hold");
    tick();
  endtask
  task automatic load(bit sel, logic [7:0] st, logic [31:0] vals[$]);
    logic [7:0] a;
    mode = {16'h0, st, 1'b0, sel, 6'h02};
    foreach (vals[i]) begin
      in_data = vals[i];
      a = st + 8'(i);
      if (sel) wm[a] = vals[i];
      else am[a] = vals[i];
      push(cyc + 1, mout, "load_hold");
      tick();
    end
    idle();
  endtask
  task automatic mac(int n, logic [7:0] wb, logic [7:0] ab, bit relu, int stall_at, int stall_len);
    logic [31:0] r;
    r = mac_ref(n, wb, ab, relu);
    mode = {ab, wb, 8'(n), 3'b0, relu, 4'd1};
    for (int e = 0; e <= n + 3; e++) begin
      if (e == stall_at) begin
        enable = 1'b0;
        repeat (stall_len) begin
          push(cyc + 1, mout, "mac_stall");
          tick();
        end
        enable = 1'b1;
      end
      push(cyc + 1, (e >= n + 2) ? r : mout, (e >= n + 2) ? "mac_result" : "mac_busy");
      tick();
    end
    mout = r;
    idle();
  endtask
  task automatic dump(bit sel, logic [7:0] st, int len);
    logic [7:0] a;
    mode = {16'h0, st, 1'b0, sel, 6'h03};
    for (int e = 0; e <= len; e++) begin
      a = st + 8'(e - 1);
      if (e > 0) mout = sel ? wm[a] : am[a];
      push(cyc + 1, mout, "dump");
      tick();
    end
    idle();
  endtask
  task automatic mac_reset();
    mode = {8'h00, 8'h00, 8'd20, 8'h01};
    repeat (4) begin
      push(cyc + 1, mout, "mac_busy");
      tick();
    end
    reset = 1'b1;
    enable = 1'b0;
    mode = '0;
    push(cyc + 1, '0, "reset_mid_mac");
    tick();
    reset = 1'b0;
    enable = 1'b1;
    mout = '0;
    idle();
  endtask
  initial begin
    logic [31:0] q[$];
    int n, len, sa;
    enable = 1'b1;
    reset = 1'b1;
    mode = '0;
    in_data = '0;
    tick();
    push(cyc + 1, '0, "reset");
    tick();
    reset = 1'b0;
    total++;
    if (out_data === '0) passed++;
    else $display("FAIL direct_reset: out_data=%h expected 0", out_data);
    idle();
    for (int s = 0; s < 2; s++) begin
      q = {};
      repeat (256) q.push_back($urandom);
      load(1'(s), 8'h00, q);
    end
    q = {32'd3, 32'hFFFFFFFE};
    load(1'b1, 8'h00, q);
    q = {32'd5, 32'd7};
    load(1'b0, 8'h00, q);
    mac(2, 8'h00, 8'h00, 1'b0, -1, 0);
    total++;
    if (out_data === 32'd1) passed++;
    else $display("FAIL direct_mac: out_data=%h expected 1", out_data);
    q = {32'hFFFFFFFD, 32'd1};
    load(1'b1, 8'h10, q);
    q = {32'd5, 32'd7};
    load(1'b0, 8'h10, q);
    mac(2, 8'h10, 8'h10, 1'b1, -1, 0);
    mac(2, 8'h10, 8'h10, 1'b0, -1, 0);
    dump(1'b0, 8'h00, 2);
    dump(1'b1, 8'h00, 2);
    mac(2, 8'h00, 8'h00, 1'b0, 2, 5);
    mac_reset();
    mac(0, 8'h00, 8'h00, 1'b0, -1, 0);
    q = {32'h7FFFFFFF, 32'h7FFFFFFF};
    load(1'b1, 8'h00, q);
    load(1'b0, 8'h00, q);
    mac(2, 8'h00, 8'h00, 1'b0, -1, 0);
    total++;
`ifdef SATURATE_EN
    if (out_data === 32'h7FFFFFFF) passed++;
`else
    if (out_data === 32'h00000002) passed++;
`endif
    else $display("FAIL direct_sat: out_data=%h", out_data);
    q = {32'd9, 32'd4};
    load(1'b1, 8'hFF, q);
    mac(2, 8'hFF, 8'h00, 1'b0, -1, 0);
    dump(1'b1, 8'hFE, 4);
    repeat (60) begin
      case ($urandom_range(0, 2))
        0: begin
          q = {};
          len = int'($urandom_range(1, 6));
          repeat (len) q.push_back($urandom);
          load(1'($urandom_range(0, 1)), 8'($urandom), q);
        end
        1: begin
          n = int'($urandom_range(0, 12));
          sa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n + 1)) : -1;
          mac(n, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), sa, int'($urandom_range(1, 5)));
        end
        default: dump(1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(1, 6)));
      endcase
    end
    repeat (3) tick();
    while (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      total++;
      $display("FAIL %s never checked: expected %h at cyc %0d", mon_e.t, mon_e.v, mon_e.c);
    end
    $display("%0d/%0d checks passed", passed, total);
    if (passed === total) $display("PASS");
    else $display("FAIL %0d checks failed", total - passed);
    $finish;
  end
endmodule
